axis_cmd_gen_s2mm: RTL and testbench

Command generator for the write (S2MM) side of the AXI DataMover capture path. It turns a register-level write_start into a stream of fixed-size 72-bit S2MM commands that walk a ring buffer [base_addr, base_addr+cap_size). It also consumes the S2MM status stream, tracks outstanding commands, and reports completion, wrap and error state back to the register file.
- Sits beside the S2MM DataMover instance in the write DMA wrapper, on the command/status clock.

---
 rtl/dma_pkg.sv | 30 +++
 rtl/axis_cmd_gen_s2mm.sv | 161 ++++++++++++++++
 tb/tb_axis_cmd_gen_s2mm.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DataMover command generators: command/status field
// positions, generator FSM states and the default transfer size.
package dma_pkg;

  localparam int unsigned PACKET_SIZE_DEF = 4096;

  localparam int unsigned CMD_BTT_LSB   = 0;
  localparam int unsigned CMD_BTT_MSB   = 22;
  localparam int unsigned CMD_TYPE      = 23;
  localparam int unsigned CMD_EOF       = 30;
  localparam int unsigned CMD_SADDR_LSB = 32;
  localparam int unsigned CMD_TAG_LSB   = 64;

  localparam int unsigned STS_OKAY   = 7;
  localparam int unsigned STS_SLVERR = 6;
  localparam int unsigned STS_DECERR = 5;
  localparam int unsigned STS_INTERR = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } cmd_state_e;

  // A ring must hold at least one packet and be a whole number of packets.
  function automatic logic size_ok(input logic [31:0] size, input int unsigned pkt);
    return (size >= pkt) && ((size & (pkt - 1)) == 32'd0);
  endfunction

endpackage

// File: rtl/axis_cmd_gen_s2mm.sv
// S2MM command generator: walks a ring buffer in PACKET_SIZE commands, tracks
// outstanding commands against returned status and reports progress/errors.
module axis_cmd_gen_s2mm
  import dma_pkg::*;
#(
  parameter int unsigned PACKET_SIZE     = PACKET_SIZE_DEF,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [71:0]       m_axis_cmd_tdata,
  output logic              m_axis_cmd_tvalid,
  input  logic              m_axis_cmd_tready,
  input  logic [7:0]        s_axis_sts_tdata,
  input  logic              s_axis_sts_tvalid,
  output logic              s_axis_sts_tready,
  input  logic              write_start,
  input  logic              write_reset,
  input  logic              continuous,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] cap_size,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              sts_err,
  output logic [7:0]        last_sts,
  output logic [31:0]       pkt_count,
  output logic [7:0]        wrap_count
);

  localparam logic [ADDR_W-1:0] PKT_A   = ADDR_W'(PACKET_SIZE);
  localparam logic [ADDR_W:0]   PKT_EXT = (ADDR_W + 1)'(PACKET_SIZE);
  localparam logic [3:0]        MAX_OUT = 4'(MAX_OUTSTANDING);

  cmd_state_e        r_state, w_state_nx;
  logic              r_start_d;
  logic              r_tvalid;
  logic [ADDR_W-1:0] r_base, r_cap, r_addr;
  logic [3:0]        r_tag;
  logic [3:0]        r_out, w_out_nx;
  logic              r_done, r_cfg_err, r_sts_err;
  logic [7:0]        r_last_sts, r_wrap;
  logic [31:0]       r_pkt;

  logic              w_rst, w_start_edge, w_cfg_ok, w_hs, w_sts, w_ring_end, w_sts_bad;
  logic [ADDR_W:0]   w_next_sum, w_ring_lim;
  logic [71:0]       w_cmd;

  assign w_rst        = rst | write_reset;
  assign w_start_edge = write_start & ~r_start_d;
  assign w_cfg_ok     = size_ok(cap_size, PACKET_SIZE);
  assign w_hs         = r_tvalid & m_axis_cmd_tready;
  assign w_sts        = s_axis_sts_tvalid;
  assign w_next_sum   = {1'b0, r_addr} + PKT_EXT;
  assign w_ring_lim   = {1'b0, r_base} + {1'b0, r_cap};
  assign w_ring_end   = (w_next_sum >= w_ring_lim);
  assign w_sts_bad    = ~s_axis_sts_tdata[STS_OKAY] | s_axis_sts_tdata[STS_SLVERR] |
                        s_axis_sts_tdata[STS_DECERR] | s_axis_sts_tdata[STS_INTERR];

  // A handshake and a status beat in the same cycle cancel; status never underflows.
  always_comb begin
    w_out_nx = r_out;
    if (w_hs && !w_sts)
      w_out_nx = r_out + 4'd1;
    else if (!w_hs && w_sts && (r_out != '0))
      w_out_nx = r_out - 4'd1;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_start_edge && w_cfg_ok) w_state_nx = ISSUE;
      ISSUE:   if (w_hs && w_ring_end && !continuous) w_state_nx = DRAIN;
      DRAIN:   if (r_out == '0) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_start_d  <= 1'b0;
      r_tvalid   <= 1'b0;
      r_base     <= '0;
      r_cap      <= '0;
      r_addr     <= '0;
      r_tag      <= '0;
      r_out      <= '0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_sts_err  <= 1'b0;
      r_last_sts <= '0;
      r_pkt      <= '0;
      r_wrap     <= '0;
    end else begin
      r_start_d <= write_start;
      r_out     <= w_out_nx;
      // Valid only from the cycle after ISSUE entry, and only with credit left.
      r_tvalid  <= (r_state == ISSUE) && (w_state_nx == ISSUE) && (w_out_nx < MAX_OUT);

      if (w_sts) begin
        r_pkt      <= r_pkt + 32'd1;
        r_last_sts <= s_axis_sts_tdata;
        if (w_sts_bad) r_sts_err <= 1'b1;
      end

      if (w_hs) begin
        r_tag <= r_tag + 4'd1;
        if (!w_ring_end) begin
          r_addr <= r_addr + PKT_A;
        end else if (continuous) begin
          r_addr <= r_base;
          if (r_wrap != 8'hFF) r_wrap <= r_wrap + 8'd1;
        end
      end

      if ((r_state == IDLE) && w_start_edge) begin
        if (w_cfg_ok) begin
          r_base    <= base_addr;
          r_cap     <= cap_size;
          r_addr    <= base_addr;
          r_tag     <= '0;
          r_done    <= 1'b0;
          r_sts_err <= 1'b0;
          r_pkt     <= '0;
          r_wrap    <= '0;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end

      if ((r_state == DRAIN) && (r_out == '0)) r_done <= 1'b1;
    end
  end

  always_comb begin
    w_cmd = '0;
    w_cmd[CMD_BTT_MSB:CMD_BTT_LSB]  = 23'(PACKET_SIZE);
    w_cmd[CMD_TYPE]                 = 1'b1;
    w_cmd[CMD_EOF]                  = 1'b1;
    w_cmd[CMD_SADDR_LSB +: ADDR_W]  = r_addr;
    w_cmd[CMD_TAG_LSB +: 4]         = r_tag;
  end

  assign m_axis_cmd_tdata  = w_cmd;
  assign m_axis_cmd_tvalid = r_tvalid;
  assign s_axis_sts_tready = 1'b1;
  assign busy              = (r_state != IDLE);
  assign done              = r_done;
  assign cfg_err           = r_cfg_err;
  assign sts_err           = r_sts_err;
  assign last_sts          = r_last_sts;
  assign pkt_count         = r_pkt;
  assign wrap_count        = r_wrap;

endmodule

// File: tb/tb_axis_cmd_gen_s2mm.sv
// Scoreboard bench for axis_cmd_gen_s2mm: expected commands are queued from a
// ring-walk model, a negedge monitor pops and compares every handshake.
module tb_axis_cmd_gen_s2mm;

  localparam int unsigned PS   = 4096;
  localparam int unsigned MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        write_start = 1'b0;
  logic        write_reset = 1'b0;
  logic        continuous = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] cap_size = '0;
  logic        busy, done, cfg_err, sts_err;
  logic [7:0]  last_sts, wrap_count;
  logic [31:0] pkt_count;

  axis_cmd_gen_s2mm #(
    .PACKET_SIZE(PS),
    .MAX_OUTSTANDING(MAXO),
    .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .m_axis_cmd_tdata(m_tdata), .m_axis_cmd_tvalid(m_tvalid), .m_axis_cmd_tready(m_tready),
    .s_axis_sts_tdata(s_tdata), .s_axis_sts_tvalid(s_tvalid), .s_axis_sts_tready(s_tready),
    .write_start(write_start), .write_reset(write_reset), .continuous(continuous),
    .base_addr(base_addr), .cap_size(cap_size),
    .busy(busy), .done(done), .cfg_err(cfg_err), .sts_err(sts_err),
    .last_sts(last_sts), .pkt_count(pkt_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  int          cyc = 0;
  logic [71:0] exp_q[$];
  int          sts_due[$];
  logic [7:0]  sts_val[$];
  bit          sts_auto = 1'b0;
  bit          rnd_ready = 1'b0;
  logic [7:0]  sts_map[16];

  function automatic logic [71:0] mk_cmd(input logic [31:0] addr, input logic [3:0] tag);
    logic [71:0] c;
    c = '0;
    c[22:0]  = 23'(PS);
    c[23]    = 1'b1;
    c[30]    = 1'b1;
    c[63:32] = addr;
    c[67:64] = tag;
    return c;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Ring walk: command i targets base + (i mod ring)*PS with tag i mod 16.
  task automatic push_pass(input logic [31:0] b, input int ring, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(mk_cmd(b + 32'((i % ring) * PS), 4'(i % 16)));
  endtask

  task automatic reset_map();
    for (int i = 0; i < 16; i++) sts_map[i] = 8'h80 | 8'(i);
  endtask

  // Monitor and automatic status responder (status 3 clk after each command).
  always @(negedge clk) begin
    logic [71:0] e;
    cyc++;
    if (m_tvalid && m_tready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected: got 0x%0h, expected none", m_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("cmd", m_tdata, e);
        if (sts_auto) begin
          sts_due.push_back(cyc + 3);
          sts_val.push_back(sts_map[e[67:64]]);
        end
      end
    end
    if (sts_auto) begin
      s_tvalid = 1'b0;
      if (sts_due.size() > 0 && sts_due[0] <= cyc) begin
        s_tvalid = 1'b1;
        s_tdata  = sts_val.pop_front();
        void'(sts_due.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) m_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic soft_reset();
    write_reset = 1'b1;
    step();
    write_reset = 1'b0;
    exp_q.delete();
    sts_due.delete();
    sts_val.delete();
    s_tvalid = 1'b0;
  endtask

  task automatic start_cap(input logic [31:0] b, input logic [31:0] c, input bit cont, input bit chk_lat);
    base_addr   = b;
    cap_size    = c;
    continuous  = cont;
    write_start = 1'b1;
    step();
    if (chk_lat) chk("lat_1clk_tvalid", 72'(m_tvalid), 72'(0));
    write_start = 1'b0;
    step();
    if (chk_lat) chk("lat_2clk_tvalid", 72'(m_tvalid), 72'(1));
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(name, 72'(done), 72'(1));
  endtask

  task automatic wait_hs(input int h0, input int k, input string name);
    int n;
    n = 0;
    while ((hs_cnt - h0) < k && n < 300) begin
      step();
      n++;
    end
    chk(name, 72'(hs_cnt - h0), 72'(k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] b;
    logic [7:0]  v;
    int          ring, k, total, h0;
    bit          seen;
    logic [7:0]  err_vals[6];
    logic [31:0] bad_caps[5];

    reset_map();
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_tvalid", 72'(m_tvalid), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_cfg_err", 72'(cfg_err), 72'(0));
    chk("rst_sts_err", 72'(sts_err), 72'(0));
    chk("rst_last_sts", 72'(last_sts), 72'(0));
    chk("rst_pkt_count", 72'(pkt_count), 72'(0));
    chk("rst_wrap_count", 72'(wrap_count), 72'(0));
    chk("sts_tready", 72'(s_tready), 72'(1));

    // Single pass
    sts_auto = 1'b1;
    m_tready = 1'b1;
    push_pass(32'h1000_0000, 4, 4);
    start_cap(32'h1000_0000, 32'h4000, 1'b0, 1'b1);
    wait_done(200, "sp_done");
    chk("sp_pkt_count", 72'(pkt_count), 72'(4));
    chk("sp_wrap_count", 72'(wrap_count), 72'(0));
    chk("sp_busy", 72'(busy), 72'(0));
    chk("sp_sts_err", 72'(sts_err), 72'(0));
    chk("sp_last_sts", 72'(last_sts), 72'(8'h83));
    chk("sp_all_cmds", 72'(exp_q.size()), 72'(0));

    rnd_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      b    = $urandom & 32'h0FFF_FF00;
      ring = $urandom_range(1, 6);
      push_pass(b, ring, ring);
      start_cap(b, 32'(ring * PS), 1'b0, 1'b0);
      chk("rp_done_cleared", 72'(done), 72'(0));
      wait_done(400, "rp_done");
      chk("rp_pkt_count", 72'(pkt_count), 72'(ring));
      chk("rp_all_cmds", 72'(exp_q.size()), 72'(0));
    end

    // Continuous wrap, continuous dropped after k commands
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        b = 32'h0; ring = 2; k = 5;
      end else begin
        b = $urandom & 32'h0FFF_F000; ring = $urandom_range(1, 3); k = $urandom_range(1, 7);
      end
      total = (k / ring + 1) * ring;
      push_pass(b, ring, total);
      h0 = hs_cnt;
      start_cap(b, 32'(ring * PS), 1'b1, 1'b0);
      wait_hs(h0, k, "cont_hs");
      continuous = 1'b0;
      wait_done(500, "cont_done");
      chk("cont_wrap_count", 72'(wrap_count), 72'(k / ring));
      chk("cont_pkt_count", 72'(pkt_count), 72'(total));
      chk("cont_all_cmds", 72'(exp_q.size()), 72'(0));
    end

    // Error status on the first packet; issuing carries on
    rnd_ready = 1'b0;
    m_tready = 1'b1;
    reset_map();
    sts_map[0] = 8'h41;
    push_pass(32'h2000_0000, 6, 6);
    start_cap(32'h2000_0000, 32'(6 * PS), 1'b0, 1'b0);
    wait_done(300, "err_done");
    chk("err_sts_err", 72'(sts_err), 72'(1));
    chk("err_pkt_count", 72'(pkt_count), 72'(6));
    chk("err_all_cmds", 72'(exp_q.size()), 72'(0));

    err_vals = '{8'h41, 8'h21, 8'h11, 8'h00, 8'h8F, 8'hC0};
    for (int t = 0; t < 6; t++) begin
      v = err_vals[t];
      reset_map();
      sts_map[1] = v;
      push_pass(32'h3000_0000, 2, 2);
      start_cap(32'h3000_0000, 32'(2 * PS), 1'b0, 1'b0);
      wait_done(200, "errtab_done");
      chk("errtab_sts_err", 72'(sts_err), 72'(!v[7] || (v[6:4] != 3'b000)));
      chk("errtab_last_sts", 72'(last_sts), 72'(v));
    end
    reset_map();

    // Mid-operation reset with tvalid=1, tready=0
    sts_auto = 1'b0;
    soft_reset();
    push_pass(32'h4000_0000, 8, 8);
    h0 = hs_cnt;
    start_cap(32'h4000_0000, 32'(8 * PS), 1'b0, 1'b0);
    wait_hs(h0, 3, "mr_hs");
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'h83;
    step();
    s_tvalid = 1'b0;
    step();
    chk("mr_pre_tvalid", 72'(m_tvalid), 72'(1));
    chk("mr_pre_pkt_count", 72'(pkt_count), 72'(1));
    soft_reset();
    chk("mr_tvalid", 72'(m_tvalid), 72'(0));
    chk("mr_busy", 72'(busy), 72'(0));
    chk("mr_pkt_count", 72'(pkt_count), 72'(0));
    chk("mr_last_sts", 72'(last_sts), 72'(0));
    chk("mr_wrap_count", 72'(wrap_count), 72'(0));

    // Backpressure, stall stability and simultaneous handshake+status
    m_tready = 1'b1;
    push_pass(32'h5000_0000, 8, 8);
    h0 = hs_cnt;
    start_cap(32'h5000_0000, 32'(8 * PS), 1'b0, 1'b0);
    repeat (20) step();
    chk("bp_hs_limit", 72'(hs_cnt - h0), 72'(MAXO));
    chk("bp_tvalid_low", 72'(m_tvalid), 72'(0));
    s_tvalid = 1'b1;
    s_tdata  = 8'h80;
    step();
    s_tvalid = 1'b0;
    repeat (10) step();
    chk("bp_one_more", 72'(hs_cnt - h0), 72'(MAXO + 1));
    chk("bp_tvalid_low2", 72'(m_tvalid), 72'(0));
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'h81;
    step();
    s_tvalid = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 10; i++) begin
      chk("stall_tvalid", 72'(m_tvalid), 72'(1));
      chk("stall_tdata", m_tdata, exp_q[0]);
      step();
    end
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 8'h82;
    step();
    s_tvalid = 1'b0;
    repeat (10) step();
    chk("simul_net_zero", 72'(hs_cnt - h0), 72'(MAXO + 3));
    chk("simul_tvalid_low", 72'(m_tvalid), 72'(0));
    soft_reset();

    // Rejected configurations
    bad_caps = '{32'h1800, 32'h0, 32'h0800, 32'h1001, 32'(PS) + 32'($urandom_range(1, PS - 1))};
    for (int t = 0; t < 5; t++) begin
      soft_reset();
      chk("cfg_clear", 72'(cfg_err), 72'(0));
      start_cap(32'h6000_0000, bad_caps[t], 1'b0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        seen = seen | m_tvalid | busy;
        step();
      end
      chk("cfg_err_set", 72'(cfg_err), 72'(1));
      chk("cfg_busy", 72'(busy), 72'(0));
      chk("cfg_no_activity", 72'(seen), 72'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
